spi_master_param: RTL

Parametrised successor SPI master with a generic data width, all four CPOL/CPHA modes, MSB- or LSB-first order, a programmable SCLK divider and multiple active-low slave selects. It is driven by the same register-style host bus used across the design: cs, wr, rd, addr, in_data and out_data. It is a pure master with one transfer in flight; slaves sit on sclk/mosi/miso/ss_n.

---
 rtl/spi_master_param.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DW-bit transfers, CPOL/CPHA modes, MSB/LSB order,
// programmable half-period divider and NSS active-low slave selects.
module spi_master_param #(
  parameter int DW      = 8,
  parameter int NSS     = 4,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs,
  input  logic           wr,
  input  logic           rd,
  input  logic [1:0]     addr,
  input  logic [DW-1:0]  in_data,
  output logic [DW-1:0]  out_data,
  output logic           sclk,
  output logic           mosi,
  input  logic           miso,
  output logic [NSS-1:0] ss_n,
  output logic           irq
);
  // ss_idx is one bit wider when NSS is a power of two so that NSS itself
  // (the "no slave" select) can be encoded.
  localparam int SSW = $clog2(NSS + 1);
  localparam int CW  = SSW + 3;
  localparam int EW  = $clog2(2 * DW);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0] clkdiv, cnt;
  logic [CW-1:0]    ctrl;
  logic [DW-1:0]    rx, tx_sh, rx_sh;
  logic [EW-1:0]    edge_cnt;
  logic             sclk_q, done, err;

  logic           cpol, cpha, lsb_first;
  logic [SSW-1:0] ss_idx;
  assign cpol      = ctrl[0];
  assign cpha      = ctrl[1];
  assign lsb_first = ctrl[2];
  assign ss_idx    = ctrl[CW-1:3];

  logic wr_en, rd_en, busy, start, bad_wr, tick, last_edge, odd_edge, samp, drv;
  assign wr_en     = cs && wr;
  assign rd_en     = cs && rd && !wr;
  assign busy      = (state != IDLE);
  assign start     = wr_en && (addr == 2'd0) && !busy;
  assign bad_wr    = wr_en && (addr != 2'd1) && busy;
  assign tick      = (cnt == '0);
  assign last_edge = (edge_cnt == EW'(2 * DW - 1));
  assign odd_edge  = ~edge_cnt[0];
  assign samp      = cpha ? !odd_edge : odd_edge;
  // cpha=0 already put bit 0 out during SETUP, so its final even edge drives nothing
  assign drv       = cpha ? odd_edge : (!odd_edge && !last_edge);

  function automatic logic first_bit(input logic [DW-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] r, input logic b,
                                             input logic lsb);
    return lsb ? {b, r[DW-1:1]} : {r[DW-2:0], b};
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = XFER;
      XFER:    if (tick && last_edge) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clkdiv   <= DIV_W'(DIV_RST);
      ctrl     <= '0;
      rx       <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      sclk_q   <= 1'b0;
      mosi     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Divider counter reloads on every phase event, so each phase is CLKDIV+1 clocks
      if (state == IDLE || state == DONE || tick) cnt <= clkdiv;
      else                                        cnt <= cnt - 1'b1;

      if (wr_en && !busy) begin
        if (addr == 2'd2) clkdiv <= DIV_W'(in_data);
        if (addr == 2'd3) ctrl   <= CW'(in_data);
      end

      if (bad_wr)                                   err <= 1'b1;
      else if (wr_en && addr == 2'd1 && in_data[2]) err <= 1'b0;

      if (state == DONE)                           done <= 1'b1;
      else if (start || (rd_en && addr == 2'd0))   done <= 1'b0;

      if (start) begin
        sclk_q   <= cpol;
        edge_cnt <= '0;
        rx_sh    <= '0;
        if (!cpha) begin
          mosi  <= first_bit(in_data, lsb_first);
          tx_sh <= shift_out(in_data, lsb_first);
        end else begin
          tx_sh <= in_data;
        end
      end

      if (state == XFER && tick) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_cnt + 1'b1;
        if (samp) rx_sh <= shift_in(rx_sh, miso, lsb_first);
        if (drv) begin
          mosi  <= first_bit(tx_sh, lsb_first);
          tx_sh <= shift_out(tx_sh, lsb_first);
        end
      end

      if (state == DONE) rx <= rx_sh;
    end
  end

  assign sclk = (state == IDLE) ? cpol : sclk_q;
  assign irq  = done;

  always_comb begin
    ss_n = '1;
    if (state == SETUP || state == XFER || state == HOLD)
      for (int i = 0; i < NSS; i++)
        if (ss_idx == SSW'(i)) ss_n[i] = 1'b0;
  end

  always_comb begin
    out_data = '0;
    if (rd_en)
      case (addr)
        2'd0:    out_data = rx;
        2'd1:    out_data = DW'({err, done, busy});
        2'd2:    out_data = DW'(clkdiv);
        default: out_data = DW'(ctrl);
      endcase
  end
endmodule
